// File: rtl/sampq_fifo_if.sv
// Sample-queue bundle: producer write side, consumer read side and status
// outputs of sampq_fifo. The FIFO attaches to the slave modport.
interface sampq_fifo_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 13
);
    logic              flush;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W:0]   count;
    logic              almost_full;
    logic [15:0]       overflow_cnt;

    modport master (
        output flush, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, count, almost_full, overflow_cnt
    );

    modport slave (
        input  flush, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, count, almost_full, overflow_cnt
    );
endinterface

// File: rtl/sampq_fifo.sv
// Block-RAM sample queue with a 2-entry output stage that hides the RAM read
// latency, plus occupancy/almost-full status, full policy and flush.
module sampq_fifo #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 13,
    parameter int AFULL_LVL    = (2**ADDR_W) - 64,
    parameter int DROP_ON_FULL = 0
) (
    input logic         clk,
    input logic         rst_n,
    sampq_fifo_if.slave bus
);
    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_C = (ADDR_W+1)'(AFULL_LVL);
    localparam logic            DROP_C  = (DROP_ON_FULL != 0);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   ram_cnt;
    logic [15:0]       ovf;

    logic              full;
    logic              push;
    logic              pop;
    logic              drop;

    logic              rd_en_p0;
    logic              rd_vld_p1;
    logic [DATA_W-1:0] rd_data_p1;

    logic [1:0]        st_cnt;
    logic [1:0]        st_cnt_nxt;
    logic [DATA_W-1:0] st_d0;
    logic [DATA_W-1:0] st_d1;
    logic [DATA_W-1:0] st_d0_nxt;
    logic [DATA_W-1:0] st_d1_nxt;
    logic [2:0]        occ;

    assign full     = (cnt == DEPTH_C);
    assign bus.in_ready = DROP_C ? 1'b1 : ~full;
    assign push     = bus.in_valid & bus.in_ready & ~bus.flush & ~full;
    assign pop      = (st_cnt != 2'd0) & bus.out_ready & ~bus.flush;
    assign drop     = DROP_C & bus.in_valid & ~bus.flush & full;

    // cnt covers RAM + read in flight + stage, so the RAM share falls out by subtraction
    assign ram_cnt  = cnt - (ADDR_W+1)'(st_cnt) - (ADDR_W+1)'(rd_vld_p1);
    assign occ      = {1'b0, st_cnt} + {2'b00, rd_vld_p1} - {2'b00, pop};
    assign rd_en_p0 = (ram_cnt != '0) & (occ < 3'd2) & ~bus.flush;

    // ---- stage p0 -> p1: RAM write and synchronous read ----
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= bus.in_data;
        end
        if (rd_en_p0) begin
            rd_data_p1 <= mem[rptr];
        end
    end

    // Head only moves on a pop from a 2-deep stage, so an emptied stage keeps the last word visible
    always_comb begin
        st_cnt_nxt = st_cnt;
        st_d0_nxt  = st_d0;
        st_d1_nxt  = st_d1;
        if (pop) begin
            st_cnt_nxt = st_cnt - 2'd1;
            if (st_cnt == 2'd2) begin
                st_d0_nxt = st_d1;
            end
        end
        if (rd_vld_p1) begin
            if (st_cnt_nxt == 2'd0) begin
                st_d0_nxt = rd_data_p1;
            end else begin
                st_d1_nxt = rd_data_p1;
            end
            st_cnt_nxt = st_cnt_nxt + 2'd1;
        end
    end

    // ---- stage p1 -> output: pointers, occupancy and stage control ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            cnt       <= '0;
            st_cnt    <= 2'd0;
            rd_vld_p1 <= 1'b0;
            ovf       <= 16'd0;
        end else if (bus.flush) begin
            wptr      <= '0;
            rptr      <= '0;
            cnt       <= '0;
            st_cnt    <= 2'd0;
            rd_vld_p1 <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_en_p0) begin
                rptr <= rptr + 1'b1;
            end
            rd_vld_p1 <= rd_en_p0;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            st_cnt <= st_cnt_nxt;
            if (drop) begin
                ovf <= sat_inc16(ovf);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_d0 <= '0;
        end else if (!bus.flush) begin
            st_d0 <= st_d0_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!bus.flush) begin
            st_d1 <= st_d1_nxt;
        end
    end

    assign bus.out_valid    = (st_cnt != 2'd0);
    assign bus.out_data     = st_d0;
    assign bus.count        = cnt;
    assign bus.almost_full  = (cnt >= AFULL_C);
    assign bus.overflow_cnt = ovf;
endmodule
